// File: rtl/apb_i2c_regif_if.sv
// APB slave bus bundle for the I2C register interface.
// Handshake: a transfer is a setup cycle (PSELx=1, PENABLE=0) followed by one or more
// access cycles (PSELx=1, PENABLE=1); it completes on the rising edge where PREADY=1,
// and PSLVERR is meaningful only in that completing cycle.
interface apb_i2c_regif_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              PSELx;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_i2c_regif.sv
// APB register front-end for an I2C core: TX/RX FIFO ports, config/timeout
// registers, status, and a sticky interrupt block with enable mask.
module apb_i2c_regif #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int CFG_W  = 14,
  parameter int TO_W   = 14
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  apb_i2c_regif_if.slave    apb,
  output logic [DATA_W-1:0] TX_DATA,
  output logic              TX_PUSH,
  input  logic              TX_FULL,
  input  logic              TX_EMPTY,
  input  logic [DATA_W-1:0] RX_DATA,
  output logic              RX_POP,
  input  logic              RX_EMPTY,
  input  logic              ERROR,
  output logic [CFG_W-1:0]  CFG,
  output logic [TO_W-1:0]   TIMEOUT,
  output logic              IRQ,
  output logic              state_dbg
);

  typedef enum logic {IDLE = 1'b0, RXWAIT = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] A_TX  = ADDR_W'('h00);
  localparam logic [ADDR_W-1:0] A_RX  = ADDR_W'('h04);
  localparam logic [ADDR_W-1:0] A_CFG = ADDR_W'('h08);
  localparam logic [ADDR_W-1:0] A_TO  = ADDR_W'('h0C);
  localparam logic [ADDR_W-1:0] A_ST  = ADDR_W'('h10);
  localparam logic [ADDR_W-1:0] A_IEN = ADDR_W'('h14);
  localparam logic [ADDR_W-1:0] A_IST = ADDR_W'('h18);

  state_t            state;
  logic [DATA_W-1:0] prdata_q;
  logic [CFG_W-1:0]  cfg_q;
  logic [TO_W-1:0]   to_q;
  logic [2:0]        irq_en_q;
  logic [2:0]        irq_stat_q;
  logic [2:0]        irq_stat_nxt;
  logic              irq_q;

  logic is_tx, is_rx, is_cfg, is_to, is_st, is_ien, is_ist, mapped;
  logic access, setup_rd, rx_ok, err, wr_ok;
  logic [DATA_W-1:0] rd_mux;

  // Full-width compare against aligned constants also rejects misaligned offsets.
  assign is_tx  = (apb.PADDR == A_TX);
  assign is_rx  = (apb.PADDR == A_RX);
  assign is_cfg = (apb.PADDR == A_CFG);
  assign is_to  = (apb.PADDR == A_TO);
  assign is_st  = (apb.PADDR == A_ST);
  assign is_ien = (apb.PADDR == A_IEN);
  assign is_ist = (apb.PADDR == A_IST);
  assign mapped = is_tx | is_rx | is_cfg | is_to | is_st | is_ien | is_ist;

  assign access   = apb.PSELx & apb.PENABLE & (state == IDLE);
  assign setup_rd = apb.PSELx & ~apb.PENABLE & ~apb.PWRITE & ~is_rx & (state == IDLE);
  assign err      = ~mapped
                  | ( apb.PWRITE & (is_rx | is_st | (is_tx & TX_FULL)))
                  | (~apb.PWRITE & (is_tx | (is_rx & RX_EMPTY)));
  assign rx_ok    = access & ~apb.PWRITE & is_rx & ~RX_EMPTY;
  assign wr_ok    = PRESETn & access & apb.PWRITE & ~err;

  // A good RXDATA read stalls one cycle; every other access completes immediately.
  assign apb.PREADY  = PRESETn & ((state == RXWAIT) | (access & ~rx_ok));
  assign apb.PSLVERR = PRESETn & access & err;
  assign apb.PRDATA  = prdata_q;

  assign TX_DATA   = apb.PWDATA;
  assign TX_PUSH   = wr_ok & is_tx;
  assign RX_POP    = PRESETn & rx_ok;
  assign CFG       = cfg_q;
  assign TIMEOUT   = to_q;
  assign IRQ       = irq_q;
  assign state_dbg = state;

  always_comb begin
    rd_mux = '0;
    if (is_cfg) rd_mux[CFG_W-1:0] = cfg_q;
    if (is_to)  rd_mux[TO_W-1:0]  = to_q;
    if (is_st)  rd_mux[3:0]       = {ERROR, TX_FULL, TX_EMPTY, RX_EMPTY};
    if (is_ien) rd_mux[2:0]       = irq_en_q;
    if (is_ist) rd_mux[2:0]       = irq_stat_q;
  end

  // Sources are OR'd in after the W1C mask so a live source wins over a clear.
  always_comb begin
    irq_stat_nxt = irq_stat_q;
    if (wr_ok && is_ist) irq_stat_nxt = irq_stat_nxt & ~apb.PWDATA[2:0];
    irq_stat_nxt = irq_stat_nxt | {ERROR, ~RX_EMPTY, TX_EMPTY};
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state      <= IDLE;
      prdata_q   <= '0;
      cfg_q      <= '0;
      to_q       <= '0;
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_stat_q <= irq_stat_nxt;
      irq_q      <= |(irq_stat_q & irq_en_q);
      case (state)
        IDLE: begin
          if (rx_ok) begin
            prdata_q <= RX_DATA;
            state    <= RXWAIT;
          end else if (setup_rd) begin
            prdata_q <= rd_mux;
          end
          if (wr_ok) begin
            if (is_cfg) cfg_q    <= apb.PWDATA[CFG_W-1:0];
            if (is_to)  to_q     <= apb.PWDATA[TO_W-1:0];
            if (is_ien) irq_en_q <= apb.PWDATA[2:0];
          end
        end
        RXWAIT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_i2c_regif.sv
// Directed bench for apb_i2c_regif: a vector table of single APB transfers plus
// hand-written sequences for reset, interrupt and RXWAIT corner cases.
module tb_apb_i2c_regif;

  logic        PCLK;
  logic        PRESETn;
  logic [31:0] TX_DATA;
  logic        TX_PUSH;
  logic        TX_FULL;
  logic        TX_EMPTY;
  logic [31:0] RX_DATA;
  logic        RX_POP;
  logic        RX_EMPTY;
  logic        ERROR;
  logic [13:0] CFG;
  logic [13:0] TIMEOUT;
  logic        IRQ;
  logic        state_dbg;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  apb_i2c_regif_if #(.DATA_W(32), .ADDR_W(8)) bus ();

  apb_i2c_regif #(.DATA_W(32), .ADDR_W(8), .CFG_W(14), .TO_W(14)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus),
    .TX_DATA(TX_DATA), .TX_PUSH(TX_PUSH), .TX_FULL(TX_FULL), .TX_EMPTY(TX_EMPTY),
    .RX_DATA(RX_DATA), .RX_POP(RX_POP), .RX_EMPTY(RX_EMPTY), .ERROR(ERROR),
    .CFG(CFG), .TIMEOUT(TIMEOUT), .IRQ(IRQ), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every TX_PUSH must carry the next expected word.
  always @(negedge PCLK) begin
    if (TX_PUSH) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_push_unexpected actual=%h expected=none", TX_DATA);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (TX_DATA !== e) begin
          errors++;
          $display("FAIL tx_data actual=%h expected=%h", TX_DATA, e);
        end
      end
    end
  end

  // Driver: one APB transfer, bounded wait, returns PRDATA after completion.
  task automatic apb_xfer(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output bit slverr,
                          output int waits, output int pushes, output int pops);
    bit done;
    done = 0; waits = 0; pushes = 0; pops = 0; slverr = 0;
    @(posedge PCLK); #1;
    bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
    bus.PADDR = addr; bus.PWDATA = wdata;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge PCLK);
      if (TX_PUSH) pushes++;
      if (RX_POP) pops++;
      if (bus.PREADY) begin
        done = 1;
        slverr = bus.PSLVERR;
      end else begin
        waits++;
      end
      @(posedge PCLK); #1;
    end
    bus.PSELx = 1'b0; bus.PENABLE = 1'b0;
    check("pready_timeout", {31'b0, done}, 32'd1);
    rdata = bus.PRDATA;
  endtask

  task automatic wr_reg(input logic [7:0] addr, input logic [31:0] wdata);
    logic [31:0] r; bit e; int w, p, q;
    apb_xfer(1'b1, addr, wdata, r, e, w, p, q);
    check("wr_slverr", {31'b0, e}, 32'd0);
  endtask

  task automatic rd_check(input string name, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] r; bit e; int w, p, q;
    apb_xfer(1'b0, addr, 32'h0, r, e, w, p, q);
    check(name, r, exp);
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    bit          tx_full;
    bit          tx_empty;
    bit          rx_empty;
    logic [31:0] rx_data;
    bit          chk_rd;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_waits;
    int          exp_push;
    int          exp_pop;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] rd;
    bit          se;
    int          wt, ps, pp;

    vecs[0]  = '{1, 8'h08, 32'hFFFF_3ABC, 0, 0, 1, 32'h0,         0, 32'h0,         0, 0, 0, 0};
    vecs[1]  = '{0, 8'h08, 32'h0,         0, 0, 1, 32'h0,         1, 32'h0000_3ABC, 0, 0, 0, 0};
    vecs[2]  = '{1, 8'h0C, 32'h1234_5678, 0, 0, 1, 32'h0,         0, 32'h0,         0, 0, 0, 0};
    vecs[3]  = '{0, 8'h0C, 32'h0,         0, 0, 1, 32'h0,         1, 32'h0000_1678, 0, 0, 0, 0};
    vecs[4]  = '{1, 8'h00, 32'hDEAD_BEEF, 0, 0, 1, 32'h0,         0, 32'h0,         0, 0, 1, 0};
    vecs[5]  = '{1, 8'h00, 32'h0000_0BAD, 1, 0, 1, 32'h0,         0, 32'h0,         1, 0, 0, 0};
    vecs[6]  = '{0, 8'h1C, 32'h0,         0, 0, 1, 32'h0,         1, 32'h0,         1, 0, 0, 0};
    vecs[7]  = '{0, 8'h04, 32'h0,         0, 0, 0, 32'hA5A5_0001, 1, 32'hA5A5_0001, 0, 1, 0, 1};
    vecs[8]  = '{0, 8'h04, 32'h0,         0, 0, 1, 32'h1234_0000, 1, 32'hA5A5_0001, 1, 0, 0, 0};
    vecs[9]  = '{0, 8'h0A, 32'h0,         0, 0, 1, 32'h0,         1, 32'h0,         1, 0, 0, 0};
    vecs[10] = '{1, 8'h04, 32'h1111_1111, 0, 0, 1, 32'h0,         0, 32'h0,         1, 0, 0, 0};
    vecs[11] = '{1, 8'h10, 32'h2222_2222, 0, 0, 1, 32'h0,         0, 32'h0,         1, 0, 0, 0};
    vecs[12] = '{0, 8'h00, 32'h0,         0, 0, 1, 32'h0,         1, 32'h0,         1, 0, 0, 0};
    vecs[13] = '{0, 8'h10, 32'h0,         0, 1, 1, 32'h0,         1, 32'h0000_0003, 0, 0, 0, 0};
    vecs[14] = '{1, 8'h14, 32'hFFFF_FFFD, 0, 0, 1, 32'h0,         0, 32'h0,         0, 0, 0, 0};
    vecs[15] = '{0, 8'h14, 32'h0,         0, 0, 1, 32'h0,         1, 32'h0000_0005, 0, 0, 0, 0};

    // Reset with an RXDATA access pending: no strobes, no ready.
    PRESETn = 1'b0; TX_FULL = 1'b0; TX_EMPTY = 1'b0; RX_EMPTY = 1'b0;
    RX_DATA = 32'hCAFE_0000; ERROR = 1'b0;
    bus.PSELx = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b0;
    bus.PADDR = 8'h04; bus.PWDATA = 32'h0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_pready", {31'b0, bus.PREADY}, 32'd0);
    check("rst_pslverr", {31'b0, bus.PSLVERR}, 32'd0);
    check("rst_rx_pop", {31'b0, RX_POP}, 32'd0);
    check("rst_tx_push", {31'b0, TX_PUSH}, 32'd0);
    check("rst_prdata", bus.PRDATA, 32'h0);
    check("rst_cfg", 32'(CFG), 32'h0);
    check("rst_timeout", 32'(TIMEOUT), 32'h0);
    check("rst_irq", {31'b0, IRQ}, 32'd0);
    check("rst_state", {31'b0, state_dbg}, 32'd0);
    bus.PSELx = 1'b0; bus.PENABLE = 1'b0; RX_EMPTY = 1'b1;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;

    // Vector table
    for (int i = 0; i < 16; i++) begin
      TX_FULL = vecs[i].tx_full; TX_EMPTY = vecs[i].tx_empty;
      RX_EMPTY = vecs[i].rx_empty; RX_DATA = vecs[i].rx_data;
      if (vecs[i].exp_push != 0) exp_q.push_back(vecs[i].wdata);
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, se, wt, ps, pp);
      check($sformatf("v%0d_slverr", i), {31'b0, se}, {31'b0, vecs[i].exp_err});
      check($sformatf("v%0d_waits", i), wt, vecs[i].exp_waits);
      check($sformatf("v%0d_push", i), ps, vecs[i].exp_push);
      check($sformatf("v%0d_pop", i), pp, vecs[i].exp_pop);
      if (vecs[i].chk_rd) check($sformatf("v%0d_prdata", i), rd, vecs[i].exp_rd);
    end
    check("cfg_out", 32'(CFG), 32'h0000_3ABC);
    check("timeout_out", 32'(TIMEOUT), 32'h0000_1678);
    TX_FULL = 1'b0; TX_EMPTY = 1'b0; RX_EMPTY = 1'b1;

    // Interrupt: sticky set, registered IRQ, W1C, set-wins-over-clear.
    wr_reg(8'h14, 32'h4);
    wr_reg(8'h18, 32'h7);
    rd_check("ist_cleared", 8'h18, 32'h0);
    @(posedge PCLK); #1;
    check("irq_idle", {31'b0, IRQ}, 32'd0);
    ERROR = 1'b1;
    @(posedge PCLK); #1;
    ERROR = 1'b0;
    check("irq_lag", {31'b0, IRQ}, 32'd0);
    @(posedge PCLK); #1;
    check("irq_set", {31'b0, IRQ}, 32'd1);
    rd_check("ist_err", 8'h18, 32'h4);
    wr_reg(8'h18, 32'h4);
    check("irq_hold_after_w1c", {31'b0, IRQ}, 32'd1);
    @(posedge PCLK); #1;
    check("irq_cleared", {31'b0, IRQ}, 32'd0);
    ERROR = 1'b1;
    @(posedge PCLK); #1;
    wr_reg(8'h18, 32'h4);
    rd_check("ist_set_wins", 8'h18, 32'h4);
    ERROR = 1'b0;
    @(posedge PCLK); #1;
    check("irq_still_set", {31'b0, IRQ}, 32'd1);

    // PSELx dropped in RXWAIT: the pop stands and the FSM returns to IDLE.
    RX_EMPTY = 1'b0; RX_DATA = 32'h1111_2222;
    @(posedge PCLK); #1;
    bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 8'h04;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    @(negedge PCLK);
    check("drop_pop", {31'b0, RX_POP}, 32'd1);
    check("drop_wait", {31'b0, bus.PREADY}, 32'd0);
    @(posedge PCLK); #1;
    bus.PSELx = 1'b0; bus.PENABLE = 1'b0; RX_EMPTY = 1'b1;
    check("drop_rxwait", {31'b0, state_dbg}, 32'd1);
    @(negedge PCLK);
    check("drop_ready", {31'b0, bus.PREADY}, 32'd1);
    check("drop_no_pop", {31'b0, RX_POP}, 32'd0);
    @(posedge PCLK); #1;
    check("drop_idle", {31'b0, state_dbg}, 32'd0);
    check("drop_prdata", bus.PRDATA, 32'h1111_2222);

    // Reset while in RXWAIT: abort, popped word discarded, registers cleared.
    RX_EMPTY = 1'b0; RX_DATA = 32'h3333_4444;
    @(posedge PCLK); #1;
    bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 8'h04;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    check("rr_rxwait", {31'b0, state_dbg}, 32'd1);
    PRESETn = 1'b0; RX_EMPTY = 1'b1;
    @(negedge PCLK);
    check("rr_pready_in_rst", {31'b0, bus.PREADY}, 32'd0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1; bus.PSELx = 1'b0; bus.PENABLE = 1'b0;
    check("rr_state", {31'b0, state_dbg}, 32'd0);
    check("rr_prdata", bus.PRDATA, 32'h0);
    check("rr_cfg", 32'(CFG), 32'h0);
    check("rr_timeout", 32'(TIMEOUT), 32'h0);
    check("rr_irq", {31'b0, IRQ}, 32'd0);
    @(negedge PCLK);
    check("rr_pready", {31'b0, bus.PREADY}, 32'd0);
    rd_check("rr_ien", 8'h14, 32'h0);
    rd_check("rr_ist", 8'h18, 32'h0);

    check("tx_queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_i2c_regif.md
APB_I2C_REGIF -- requirements
Module: apb_i2c_regif

Interface
REQ-001 SHALL have parameter DATA_W, default 32, APB data width and TX/RX word width (8..32).
REQ-002 SHALL have parameter ADDR_W, default 8, decoded PADDR width (>=5).
REQ-003 SHALL have parameter CFG_W, default 14, CONFIG register width (1..DATA_W).
REQ-004 SHALL have parameter TO_W, default 14, TIMEOUT register width (1..DATA_W).
REQ-005 SHALL have ports, one per line:
 PCLK  in  1  clock; all logic on rising edge.
 PRESETn  in  1  synchronous, active-low reset.
 PSELx  in  1  APB select.
 PENABLE  in  1  APB access phase.
 PWRITE  in  1  1=write, 0=read.
 PADDR  in  ADDR_W  byte address.
 PWDATA  in  DATA_W  write data.
 PRDATA  out  DATA_W  registered read data.
 PREADY  out  1  transfer complete.
 PSLVERR  out  1  transfer error, valid only with PREADY.
 TX_DATA  out  DATA_W  word to TX FIFO.
 TX_PUSH  out  1  one-cycle TX FIFO write strobe.
 TX_FULL  in  1  TX FIFO full.
 TX_EMPTY  in  1  TX FIFO empty.
 RX_DATA  in  DATA_W  RX FIFO head word (show-ahead).
 RX_POP  out  1  one-cycle RX FIFO read strobe.
 RX_EMPTY  in  1  RX FIFO empty.
 ERROR  in  1  I2C core error level.
 CFG  out  CFG_W  CONFIG register.
 TIMEOUT  out  TO_W  TIMEOUT register.
 IRQ  out  1  registered interrupt.

Function
REQ-006 Map (byte offset, PADDR[1:0] must be 0): 0x00 TXDATA W; 0x04 RXDATA R; 0x08 CONFIG RW; 0x0C TIMEOUT RW; 0x10 STATUS R; 0x14 IRQ_EN RW [2:0]; 0x18 IRQ_STAT R/W1C [2:0].
REQ-007 STATUS SHALL read {ERROR, TX_FULL, TX_EMPTY, RX_EMPTY} in bits [3:0]; all reads zero-extended to DATA_W.
REQ-008 Writes SHALL take PWDATA LSBs of register width; upper bits ignored.
REQ-009 FSM states IDLE, RXWAIT; only a non-erroring RXDATA read leaves IDLE.
REQ-010 IDLE, PSELx&PENABLE, not RXDATA read: PREADY=1 same cycle (zero wait states); side effect on that edge.
REQ-011 IDLE, PSELx&PENABLE, RXDATA read, RX_EMPTY=0: RX_POP=1 one cycle, RX_DATA captured into PRDATA, PREADY=0, go RXWAIT.
REQ-012 RXWAIT: PREADY=1, PSLVERR=0, RX_POP=0, return IDLE unconditionally.
REQ-013 Other reads SHALL load PRDATA at the setup edge (PSELx=1, PENABLE=0); PRDATA holds otherwise.
REQ-014 TXDATA write, TX_FULL=0: TX_DATA=PWDATA, TX_PUSH=1 for exactly the PREADY cycle.
REQ-015 PSLVERR=1 with PREADY (zero wait) and no side effect for: unmapped offset, PADDR[1:0]!=0, TXDATA write with TX_FULL=1, RXDATA read with RX_EMPTY=1, write to RXDATA/STATUS, read of TXDATA.
REQ-016 IRQ_STAT bits SHALL be sticky-set each cycle source is high: bit0 TX_EMPTY, bit1 !RX_EMPTY, bit2 ERROR.
REQ-017 W1C write SHALL clear bits written 1; simultaneous set and clear of a bit: set wins.
REQ-018 IRQ SHALL be registered |(IRQ_STAT & IRQ_EN), one cycle after the state change.
REQ-019 PSELx=0 or PENABLE=0 in IDLE: PREADY=0, PSLVERR=0, no strobes.
REQ-020 PSELx dropped during RXWAIT SHALL not abort: pop already done, FSM returns IDLE.

Reset
REQ-021 PRESETn=0 at a rising edge SHALL set state IDLE, PRDATA=0, CFG=0, TIMEOUT=0, IRQ_EN=0, IRQ_STAT=0, IRQ=0.
REQ-022 Reset in RXWAIT SHALL abort to IDLE with PREADY=0; popped word discarded.
REQ-023 TX_PUSH, RX_POP, PREADY, PSLVERR SHALL be 0 while PRESETn=0.

Verification
REQ-024 Write 0x08 PWDATA=0xFFFF_3ABC -> PREADY same access cycle, CFG=0x3ABC, readback 0x0000_3ABC.
REQ-025 RX_EMPTY=0, RX_DATA=0xA5A5_0001, read 0x04 -> RX_POP one pulse, PREADY after 1 wait, PRDATA=0xA5A5_0001, PSLVERR=0.
REQ-026 TX_FULL=1, write 0x00 -> PREADY=1, PSLVERR=1, TX_PUSH never asserted; read 0x1C -> PSLVERR=1.
REQ-027 IRQ_EN=0x4, ERROR pulse 1 cycle -> IRQ_STAT[2]=1, IRQ=1 next cycle; W1C 0x4 with ERROR low -> IRQ=0; W1C while ERROR high -> bit stays 1.
REQ-028 Reset asserted in RXWAIT -> next cycle PREADY=0, state IDLE, all registers zero.
